pipeline_sched_ctrl: RTL and testbench
======================================

// Module: pipeline_sched_ctrl
// PURPOSE
//  Central stall/flush scheduler for the 5-stage pipeline (pc, if, id, ex, mem, wb).
//  Merges stall requests from if/id/ex/mem into one 6-bit stall vector.
//  Sequences exception/eret flushes and supplies the redirect PC.
//  Tracks consecutive-stall length for a hang watchdog.
// PARAMETERS
//  EXC_VECTOR  32'h0000_0020  redirect PC for any exception other than eret
//  ERET_CODE   32'h0000_000e  excepttype_i value that denotes eret (redirect to EPC)
//  FLUSH_LEN   1              cycles flush stays high per event (1..15)
//  CNT_W       8              width of consecutive-stall counter
//  TIMEOUT     200            stall_cnt value at which stall_timeout asserts (< 2^CNT_W)
// PORTS
//  clk                 in   1   clock, rising edge
//  rst                 in   1   synchronous reset, active-high
//  stallreq_from_if    in   1   fetch stage requests stall
//  stallreq_from_id    in   1   decode stage requests stall (load-use etc.)
//  stallreq_from_ex    in   1   execute stage requests stall (multi-cycle mul/div)
//  stallreq_from_mem   in   1   memory stage requests stall (bus wait)
//  excepttype_i        in   32  exception code from mem stage; 0 = none
//  cp0_epc_i           in   32  current EPC from CP0
//  stall               out  6   per-stage hold, bit0=pc .. bit5=wb
//  flush               out  1   clear all pipeline registers
//  new_pc              out  32  redirect target, valid while flush=1
//  stall_cnt           out  CNT_W  consecutive stalled cycles, saturating
//  stall_timeout       out  1   stall_cnt >= TIMEOUT
// BEHAVIOUR
//  Reset (sync, rst=1 at clk edge): state=RUN, flush=0, new_pc=0, stall_cnt=0,
//   stall_timeout=0, flush counter=0. While rst=1, stall=6'b000000 combinationally.
//  FSM states: RUN, STALL, FLUSH.
//   RUN  : no stall requests; stall=0.
//   STALL: any stallreq high; stall per priority table below.
//   FLUSH: flush=1, stall=0, all stallreq and excepttype_i ignored.
//  Stall vector (combinational from requests, state RUN/STALL only), highest wins:
//   mem -> 6'b011111 ; ex -> 6'b001111 ; id -> 6'b000111 ; if -> 6'b000011 ; none -> 0.
//  Transitions (evaluated each edge, rst=0):
//   RUN/STALL, excepttype_i!=0          -> FLUSH (exception beats any stall request)
//   RUN/STALL, excepttype_i==0, any req -> STALL
//   RUN/STALL, excepttype_i==0, no req  -> RUN
//   FLUSH, flush counter==FLUSH_LEN-1   -> RUN (requests resampled next cycle)
//  Flush: registered; excepttype_i seen at edge N -> flush=1 cycles N+1..N+FLUSH_LEN.
//   new_pc latched at edge N: cp0_epc_i if excepttype_i==ERET_CODE, else EXC_VECTOR;
//   held until the next flush event (not cleared on leaving FLUSH).
//  stall_cnt: +1 per cycle in which stall!=0, saturates at 2^CNT_W-1 (no wrap);
//   cleared to 0 on any cycle with stall==0, and on entering FLUSH.
//  stall_timeout = (stall_cnt >= TIMEOUT), registered with stall_cnt; clears with it.
//  Simultaneous: exception + stallreq same cycle -> stall=0 that cycle is NOT implied;
//   stall follows requests in that cycle, FLUSH wins from the next cycle.
//  Reset mid-FLUSH or mid-stall: everything returns to reset values at the next edge.
// TESTING
//  1. rst=1 for 3 cycles with all reqs=1 -> stall=0, flush=0, stall_cnt=0 throughout.
//  2. id=1 and mem=1 same cycle -> stall=6'b011111; drop mem -> 6'b000111; drop id -> 0.
//  3. ex=1 for 5 cycles -> stall=6'b001111, stall_cnt 1..5, then 0 the cycle after release.
//  4. excepttype_i=32'h8 one cycle during ex stall -> next cycle flush=1, stall=0,
//     new_pc=32'h20, stall_cnt=0; FLUSH_LEN=1 -> RUN the following cycle.
//  5. excepttype_i=32'he, cp0_epc_i=32'hbfc0_0100 -> flush=1, new_pc=32'hbfc0_0100.
//  6. mem=1 held 300 cycles (CNT_W=8) -> stall_timeout rises after 200 stalled cycles,
//     stall_cnt saturates at 255; rst mid-run -> all outputs 0 next cycle.

Source files
------------

// File: rtl/pipeline_sched_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_sched_ctrl
//   Central stall/flush scheduler for the pc/if/id/ex/mem/wb pipeline.
//   Merges the per-stage stall requests into one hold vector and sequences
//   exception/eret flushes together with the redirect PC. It also counts
//   consecutive stalled cycles so that a hang watchdog can fire.
//
// Ports
//   clk, rst           clock (rising edge), synchronous active-high reset
//   stallreq_from_*    stall requests from the if/id/ex/mem stages
//   excepttype_i       exception code from mem (0 = none, ERET_CODE = eret)
//   cp0_epc_i          current EPC, which is the redirect target for eret
//   stall[5:0]         per-stage hold, bit0 = pc .. bit5 = wb
//   flush              clears all pipeline registers (FLUSH_LEN cycles)
//   new_pc             redirect target, valid while flush = 1
//   stall_cnt          consecutive stalled cycles, saturating
//   stall_timeout      stall_cnt >= TIMEOUT
//   o_dbg_state        current FSM state (RUN=0, STALL=1, FLUSH=2)
//
// Handshake: none. The requests are levels sampled every cycle. stall
// responds to them combinationally. flush/new_pc are registered and appear
// the cycle after the exception was sampled.
// ---------------------------------------------------------------------------
module pipeline_sched_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
  parameter logic [31:0] ERET_CODE  = 32'h0000_000e,
  parameter int          FLUSH_LEN  = 1,
  parameter int          CNT_W      = 8,
  parameter int          TIMEOUT    = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_from_if,
  input  logic             stallreq_from_id,
  input  logic             stallreq_from_ex,
  input  logic             stallreq_from_mem,
  input  logic [31:0]      excepttype_i,
  input  logic [31:0]      cp0_epc_i,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic [CNT_W-1:0] stall_cnt,
  output logic             stall_timeout,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [3:0]       r_flush_cnt;
  logic [31:0]      r_new_pc;
  logic [CNT_W-1:0] r_stall_cnt;
  logic             r_stall_timeout;

  logic             w_any_req;
  logic             w_exc;
  logic             w_enter_flush;
  logic             w_flush_done;
  logic [5:0]       w_stall;
  logic [CNT_W-1:0] w_cnt_next;

  assign w_any_req     = stallreq_from_if | stallreq_from_id |
                         stallreq_from_ex | stallreq_from_mem;
  assign w_exc         = (excepttype_i != 32'd0);
  assign w_enter_flush = (r_state != ST_FLUSH) && w_exc;
  assign w_flush_done  = (r_flush_cnt == 4'(FLUSH_LEN - 1));

  // Next state and stall vector. A stall request raised in the same cycle
  // as an exception still holds the pipeline for that cycle; FLUSH takes
  // over from the next cycle on.
  always_comb begin
    w_next_state = r_state;
    w_stall      = 6'b000000;
    case (r_state)
      ST_RUN, ST_STALL: begin
        if (stallreq_from_mem)     w_stall = 6'b011111;
        else if (stallreq_from_ex) w_stall = 6'b001111;
        else if (stallreq_from_id) w_stall = 6'b000111;
        else if (stallreq_from_if) w_stall = 6'b000011;

        if (w_exc)          w_next_state = ST_FLUSH;
        else if (w_any_req) w_next_state = ST_STALL;
        else                w_next_state = ST_RUN;
      end
      ST_FLUSH: begin
        if (w_flush_done) w_next_state = ST_RUN;
      end
      default: w_next_state = ST_RUN;
    endcase
    if (rst) w_stall = 6'b000000;
  end

  // The counter saturates rather than wrapping so that the watchdog cannot
  // drop out during a very long hang.
  always_comb begin
    w_cnt_next = '0;
    if (w_enter_flush)
      w_cnt_next = '0;
    else if (w_stall != 6'b000000)
      w_cnt_next = (r_stall_cnt == {CNT_W{1'b1}}) ? r_stall_cnt
                                                  : r_stall_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state         <= ST_RUN;
      r_flush_cnt     <= 4'd0;
      r_new_pc        <= 32'd0;
      r_stall_cnt     <= '0;
      r_stall_timeout <= 1'b0;
    end else begin
      r_state         <= w_next_state;
      r_stall_cnt     <= w_cnt_next;
      r_stall_timeout <= (w_cnt_next >= CNT_W'(TIMEOUT));

      if (r_state == ST_FLUSH)
        r_flush_cnt <= w_flush_done ? 4'd0 : r_flush_cnt + 4'd1;
      else
        r_flush_cnt <= 4'd0;

      // new_pc stays valid after FLUSH ends, until the next exception.
      if (w_enter_flush)
        r_new_pc <= (excepttype_i == ERET_CODE) ? cp0_epc_i : EXC_VECTOR;
    end
  end

  assign stall         = w_stall;
  assign flush         = (r_state == ST_FLUSH);
  assign new_pc        = r_new_pc;
  assign stall_cnt     = r_stall_cnt;
  assign stall_timeout = r_stall_timeout;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_pipeline_sched_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_sched_ctrl
//   Directed scenarios followed by a randomized phase. A behavioural model
//   tracks the remaining flush cycles, the stall run length and the redirect
//   PC. Expected output words go through exp_q and are compared field by
//   field with immediate assertions.
// ---------------------------------------------------------------------------
module tb_pipeline_sched_ctrl;

  localparam logic [31:0] EXC_VECTOR = 32'h0000_0020;
  localparam logic [31:0] ERET_CODE  = 32'h0000_000e;
  localparam int          FLUSH_LEN  = 1;
  localparam int          CNT_W      = 8;
  localparam int          TIMEOUT    = 200;
  localparam int          CNT_MAX    = (1 << CNT_W) - 1;
  localparam int          W          = 6 + 1 + 32 + CNT_W + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             req_if, req_id, req_ex, req_mem;
  logic [31:0]      excepttype;
  logic [31:0]      epc;
  logic [5:0]       stall;
  logic             flush;
  logic [31:0]      new_pc;
  logic [CNT_W-1:0] stall_cnt;
  logic             stall_timeout;
  logic [1:0]       dbg_state;

  pipeline_sched_ctrl #(
    .EXC_VECTOR(EXC_VECTOR), .ERET_CODE(ERET_CODE), .FLUSH_LEN(FLUSH_LEN),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .stallreq_from_if(req_if), .stallreq_from_id(req_id),
    .stallreq_from_ex(req_ex), .stallreq_from_mem(req_mem),
    .excepttype_i(excepttype), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_cnt(stall_cnt), .stall_timeout(stall_timeout),
    .o_dbg_state(dbg_state)
  );

  // ---------------- reference model ----------------
  int          m_flush_left = 0;   // flush cycles still to come, incl. current
  int          m_cnt        = 0;   // consecutive stalled cycles
  logic [31:0] m_pc         = 32'd0;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  // Number of leading stages held: mem holds pc..mem (5), ex 4, id 3, if 2.
  function automatic logic [5:0] model_stall();
    int n;
    n = 0;
    if (rst || m_flush_left > 0) return 6'd0;
    if (req_mem)     n = 5;
    else if (req_ex) n = 4;
    else if (req_id) n = 3;
    else if (req_if) n = 2;
    return 6'((1 << n) - 1);
  endfunction

  // Model outcome of the coming rising edge.
  task automatic model_edge(input logic [5:0] cur_stall);
    if (rst) begin
      m_flush_left = 0; m_cnt = 0; m_pc = 32'd0;
    end else if (m_flush_left > 0) begin
      m_flush_left = m_flush_left - 1;
      m_cnt = 0;
    end else if (excepttype != 32'd0) begin
      m_flush_left = FLUSH_LEN;
      m_pc  = (excepttype == ERET_CODE) ? epc : EXC_VECTOR;
      m_cnt = 0;
    end else if (cur_stall != 6'd0) begin
      m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
    end else begin
      m_cnt = 0;
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_outputs(input string tag);
    logic [W-1:0]     e;
    logic [5:0]       e_stall;
    logic             e_flush;
    logic [31:0]      e_pc;
    logic [CNT_W-1:0] e_cnt;
    logic             e_to;
    e_stall = model_stall();
    e_flush = (m_flush_left > 0);
    e_cnt   = CNT_W'(m_cnt);
    e_to    = (m_cnt >= TIMEOUT);
    exp_q.push_back({e_stall, e_flush, m_pc, e_cnt, e_to});
    e = exp_q.pop_front();
    {e_stall, e_flush, e_pc, e_cnt, e_to} = e;

    checks++;
    assert (stall === e_stall) else begin
      errors++; $error("FAIL %s stall got %b exp %b", tag, stall, e_stall);
    end
    checks++;
    assert (flush === e_flush) else begin
      errors++; $error("FAIL %s flush got %b exp %b", tag, flush, e_flush);
    end
    checks++;
    assert (new_pc === e_pc) else begin
      errors++; $error("FAIL %s new_pc got %h exp %h", tag, new_pc, e_pc);
    end
    checks++;
    assert (stall_cnt === e_cnt) else begin
      errors++; $error("FAIL %s stall_cnt got %0d exp %0d", tag, stall_cnt, e_cnt);
    end
    checks++;
    assert (stall_timeout === e_to) else begin
      errors++; $error("FAIL %s stall_timeout got %b exp %b", tag, stall_timeout, e_to);
    end
    model_edge(e_stall);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: apply inputs, let them settle, check, then
  // advance to the next falling edge (the rising edge happens in between).
  task automatic step(input string tag, input logic r, input logic [3:0] req,
                      input logic [31:0] exc, input logic [31:0] pc_in);
    rst        = r;
    req_mem    = req[3];
    req_ex     = req[2];
    req_id     = req[1];
    req_if     = req[0];
    excepttype = exc;
    epc        = pc_in;
    #1;
    check_outputs(tag);
    @(negedge clk);
  endtask

  // req bits: {mem, ex, id, if}
  initial begin
    rst = 1'b1; req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0;
    excepttype = 32'd0; epc = 32'd0;
    @(negedge clk);

    // 1. reset held with every request active
    for (int i = 0; i < 3; i++) step("rst_all_req", 1'b1, 4'b1111, 32'd0, 32'd0);

    // 2. priority: id+mem, drop mem, drop id
    step("idle", 1'b0, 4'b0000, 32'd0, 32'd0);
    step("id_mem", 1'b0, 4'b1010, 32'd0, 32'd0);
    step("id_only", 1'b0, 4'b0010, 32'd0, 32'd0);
    step("if_only", 1'b0, 4'b0001, 32'd0, 32'd0);
    step("none", 1'b0, 4'b0000, 32'd0, 32'd0);
    step("after_none", 1'b0, 4'b0000, 32'd0, 32'd0);

    // 3. ex stall for 5 cycles, then release
    for (int i = 0; i < 5; i++) step("ex_run", 1'b0, 4'b0100, 32'd0, 32'd0);
    step("ex_release", 1'b0, 4'b0000, 32'd0, 32'd0);
    step("ex_after", 1'b0, 4'b0000, 32'd0, 32'd0);

    // 4. exception during an ex stall; requests ignored while flushing
    step("ex_pre", 1'b0, 4'b0100, 32'd0, 32'd0);
    step("ex_exc", 1'b0, 4'b0100, 32'h8, 32'h1234_5678);
    step("flush_cycle", 1'b0, 4'b0100, 32'h8, 32'd0);
    step("post_flush", 1'b0, 4'b0000, 32'd0, 32'd0);
    step("post_flush2", 1'b0, 4'b0000, 32'd0, 32'd0);

    // 5. eret redirects to EPC
    step("eret", 1'b0, 4'b0000, ERET_CODE, 32'hbfc0_0100);
    step("eret_flush", 1'b0, 4'b0000, 32'd0, 32'd0);
    step("eret_after", 1'b0, 4'b0000, 32'd0, 32'd0);

    // reset arriving while flush is high
    step("exc_pre_rst", 1'b0, 4'b0000, 32'h4, 32'd0);
    step("rst_mid_flush", 1'b1, 4'b1000, 32'h4, 32'd0);
    step("after_rst_flush", 1'b0, 4'b0000, 32'd0, 32'd0);

    // 6. long mem stall: watchdog and saturation, then reset mid-stall
    for (int i = 0; i < 300; i++) step("mem_long", 1'b0, 4'b1000, 32'd0, 32'd0);
    step("rst_mid_stall", 1'b1, 4'b1000, 32'd0, 32'd0);
    step("after_rst_stall", 1'b0, 4'b0000, 32'd0, 32'd0);

    // randomized phase
    for (int i = 0; i < 600; i++) begin
      logic        r;
      logic [3:0]  rq;
      logic [31:0] ex;
      logic [31:0] pc_r;
      r    = ($urandom_range(0, 99) == 0);
      rq   = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      pc_r = $urandom;
      case ($urandom_range(0, 19))
        0:       ex = ERET_CODE;
        1:       ex = $urandom | 32'h1;
        default: ex = 32'd0;
      endcase
      step("random", r, rq, ex, pc_r);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
